ps2_key_event_ctrl: RTL

- Sits between the PS/2 byte receiver and its consumers (7-seg display driver, FIFO-based readers).
- Parses the raw scancode byte stream (set 2) with an FSM that resolves E0 (extended) and F0 (break) prefixes.
- Suppresses typematic repeats and queues decoded key events in a small FIFO with a valid/ready handshake.
- Maintains a 32-bit display word holding the last four make codes, and a press counter.

---
 rtl/ps2_key_event_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 set-2 scancode parser: resolves E0/F0 prefixes, suppresses typematic repeats,
// queues key events in a first-word-fall-through FIFO, and tracks recent makes and a press count.
module ps2_key_event_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        evt_ready,
   output logic        evt_valid,
   output logic [7:0]  evt_code,
   output logic        evt_ext,
   output logic        evt_break,
   output logic [31:0] disp_x,
   output logic [15:0] key_count,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] to_cnt;
   logic          to_hit;
   logic          is_ctrl;
   logic          dec_valid, dec_ext, dec_brk;
   logic [7:0]    dec_code;

   logic          held_valid, held_ext;
   logic [7:0]    held_code;
   logic          held_match, mk_acc, push, pop, full, wr_ok;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [9:0]    entry, head;
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
   logic [CW-1:0] count, cnt_after;

   assign is_ctrl = (byte_in == 8'h00) || (byte_in == 8'hAA) || (byte_in == 8'hEE) ||
                    (byte_in == 8'hFA) || (byte_in == 8'hFE) || (byte_in == 8'hFF) ||
                    (byte_in == 8'hE1);
   assign to_hit  = (to_cnt == TW'(TIMEOUT - 1));

   always_comb begin
      state_nx  = state;
      dec_valid = 1'b0;
      dec_ext   = 1'b0;
      dec_brk   = 1'b0;
      dec_code  = byte_in;
      if (byte_valid) begin
         unique case (state)
            S_IDLE: begin
               if (byte_in == 8'hE0)      state_nx = S_E0;
               else if (byte_in == 8'hF0) state_nx = S_F0;
               else if (!is_ctrl)         dec_valid = 1'b1;
            end
            S_E0: begin
               state_nx = S_IDLE;
               if (byte_in == 8'hF0)      state_nx = S_E0F0;
               else if (byte_in == 8'hE0) state_nx = S_E0;
               else if (byte_in != 8'h12) begin
                  dec_valid = 1'b1;
                  dec_ext   = 1'b1;
               end
            end
            S_F0: begin
               state_nx  = S_IDLE;
               dec_valid = 1'b1;
               dec_brk   = 1'b1;
            end
            S_E0F0: begin
               state_nx = S_IDLE;
               if (byte_in != 8'h12) begin
                  dec_valid = 1'b1;
                  dec_ext   = 1'b1;
                  dec_brk   = 1'b1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end else if (state != S_IDLE && to_hit) begin
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         to_cnt <= '0;
      end else begin
         state <= state_nx;
         if (byte_valid || state == S_IDLE || to_hit) to_cnt <= '0;
         else                                         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign held_match = held_valid && (held_ext == dec_ext) && (held_code == dec_code);
   assign mk_acc     = dec_valid && !dec_brk && !held_match;
   assign push       = mk_acc || (dec_valid && dec_brk);
   assign evt_valid  = (count != '0);
   assign pop        = evt_valid && evt_ready;
   assign full       = (count == CW'(FIFO_DEPTH));
   assign wr_ok      = push && (!full || pop);
   assign entry      = {dec_ext, dec_brk, dec_code};
   assign rd_ptr_nx  = rd_ptr + AW'(pop);
   assign cnt_after  = count - CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_valid <= 1'b0;
         held_ext   <= 1'b0;
         held_code  <= '0;
         disp_x     <= '0;
         key_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         if (mk_acc) begin
            held_valid <= 1'b1;
            held_ext   <= dec_ext;
            held_code  <= dec_code;
            disp_x     <= {disp_x[23:0], dec_code};
            key_count  <= key_count + 1'b1;
         end else if (dec_valid && dec_brk && held_match) begin
            held_valid <= 1'b0;
         end
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= entry;
   end

   // Head is registered so the outputs keep the last popped event while the FIFO is empty;
   // a push into a FIFO that is empty after this cycle's pop bypasses the memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nx;
         count  <= cnt_after + CW'(wr_ok);
         if (cnt_after != '0) head <= mem[rd_ptr_nx];
         else if (wr_ok)      head <= entry;
      end
   end

   assign evt_ext   = head[9];
   assign evt_break = head[8];
   assign evt_code  = head[7:0];

endmodule
